// File: rtl/tone_gen_prog.sv
// rtl/tone_gen_prog.sv - programmable square-wave tone generator, half-period ROM and one shared divider
// Note changes and note-off are applied only where wave would rise, so no half-phase is ever cut short.
module tone_gen_prog #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int NUM_NOTES = 14,
    parameter int OCT_W     = 2,
    parameter int DIV_W     = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             note_on,
    input  logic [3:0]       note_idx,
    input  logic [OCT_W-1:0] octave,
    output logic             wave,
    output logic             busy,
    output logic [3:0]       note_cur
);

    function automatic logic [63:0] calc_hp(input int i);
        logic [63:0] f;
        case (i)
            0:       f = 64'd2626;
            1:       f = 64'd2947;
            2:       f = 64'd3306;
            3:       f = 64'd3492;
            4:       f = 64'd3920;
            5:       f = 64'd4400;
            6:       f = 64'd4949;
            7:       f = 64'd5232;
            8:       f = 64'd5873;
            9:       f = 64'd6593;
            10:      f = 64'd6985;
            11:      f = 64'd7840;
            12:      f = 64'd8800;
            13:      f = 64'd9888;
            default: f = 64'd0;
        endcase
        calc_hp = (f == 64'd0) ? 64'd0 : (64'(CLK_HZ) * 64'd5) / f;
    endfunction

    localparam logic [63:0] HP_MAX = calc_hp(0);

    if (NUM_NOTES < 1 || NUM_NOTES > 14) begin : g_bad_notes
        $error("tone_gen_prog: NUM_NOTES must be 1..14");
    end
    if (HP_MAX > ((64'd1 << DIV_W) - 64'd1)) begin : g_bad_div
        $error("tone_gen_prog: DIV_W too narrow for the longest half-period");
    end

    // Unused and out-of-range slots read as 0; they are never latched.
    logic [DIV_W-1:0] hp_rom [16];
    for (genvar g = 0; g < 16; g++) begin : g_rom
        localparam logic [63:0] HPV = (g < NUM_NOTES) ? calc_hp(g) : 64'd0;
        assign hp_rom[g] = HPV[DIV_W-1:0];
    end

    typedef enum logic {IDLE, PLAY} state_t;

    state_t             state_q, state_d;
    logic               wave_q, wave_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   hp_q, hp_d;
    logic [3:0]         note_q, note_d;
    logic [OCT_W-1:0]   oct_q, oct_d;

    logic               req_valid;
    logic [DIV_W-1:0]   hp_shift;
    logic [DIV_W-1:0]   hp_sel;

    assign req_valid = note_on && (32'(note_idx) < NUM_NOTES);
    assign hp_shift  = hp_rom[note_idx] >> octave;
    assign hp_sel    = (hp_shift == '0) ? DIV_W'(1) : hp_shift;

    always_comb begin
        state_d = state_q;
        wave_d  = wave_q;
        cnt_d   = cnt_q;
        hp_d    = hp_q;
        note_d  = note_q;
        oct_d   = oct_q;
        case (state_q)
            IDLE: begin
                wave_d = 1'b0;
                if (req_valid) begin
                    state_d = PLAY;
                    wave_d  = 1'b1;
                    cnt_d   = '0;
                    hp_d    = hp_sel;
                    note_d  = note_idx;
                    oct_d   = octave;
                end
            end
            PLAY: begin
                if (cnt_q == hp_q - DIV_W'(1)) begin
                    cnt_d = '0;
                    if (wave_q) begin
                        wave_d = 1'b0;
                    end else if (!req_valid) begin
                        state_d = IDLE;
                        wave_d  = 1'b0;
                    end else begin
                        // Period boundary: the only place a new note may take over.
                        wave_d = 1'b1;
                        if (note_idx != note_q || octave != oct_q) begin
                            hp_d   = hp_sel;
                            note_d = note_idx;
                            oct_d  = octave;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wave_q  <= 1'b0;
            cnt_q   <= '0;
            hp_q    <= '0;
            note_q  <= '0;
            oct_q   <= '0;
        end else begin
            state_q <= state_d;
            wave_q  <= wave_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
        end
    end

    assign wave     = wave_q;
    assign busy     = (state_q == PLAY);
    assign note_cur = note_q;

endmodule

// File: tb/tb_tone_gen_prog.sv
// tb/tb_tone_gen_prog.sv - directed self-checking bench for tone_gen_prog
// Half-periods at CLK_HZ=26260: idx0=50, idx5=29, idx13=13.
module tb_tone_gen_prog;

    logic       clk;
    logic       rst;
    logic       note_on;
    logic [3:0] note_idx;
    logic [1:0] octave;
    logic       wave;
    logic       busy;
    logic [3:0] note_cur;

    int vectors = 0;
    int errors  = 0;

    tone_gen_prog #(
        .CLK_HZ(26260),
        .NUM_NOTES(14),
        .OCT_W(2),
        .DIV_W(24)
    ) dut (
        .clk(clk),
        .rst(rst),
        .note_on(note_on),
        .note_idx(note_idx),
        .octave(octave),
        .wave(wave),
        .busy(busy),
        .note_cur(note_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts consecutive negedge samples with wave at lvl, bounded.
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (wave === lvl && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        note_on = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; note_on = 1'b1; note_idx = 4'd0; octave = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (wave !== 1'b0) begin errors++; $display("FAIL reset_wave cyc%0d got %b exp 0", i, wave); end
            vectors++;
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc%0d got %b exp 0", i, busy); end
            vectors++;
            if (note_cur !== 4'd0) begin errors++; $display("FAIL reset_note cyc%0d got %0d exp 0", i, note_cur); end
        end
    endtask

    task automatic test_basic();
        int n;
        rst = 1'b0; note_on = 1'b1; note_idx = 4'd0; octave = 2'd0;
        @(negedge clk);
        vectors++;
        if (wave !== 1'b1) begin errors++; $display("FAIL basic_start_wave got %b exp 1", wave); end
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_start_busy got %b exp 1", busy); end
        run_len(1'b1, n);
        vectors++;
        if (n != 50) begin errors++; $display("FAIL basic_high1 got %0d exp 50", n); end
        run_len(1'b0, n);
        vectors++;
        if (n != 50) begin errors++; $display("FAIL basic_low1 got %0d exp 50", n); end
        run_len(1'b1, n);
        vectors++;
        if (n != 50) begin errors++; $display("FAIL basic_high2 got %0d exp 50", n); end
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
    endtask

    task automatic test_octave();
        int n;
        do_reset();
        rst = 1'b0; note_on = 1'b1; note_idx = 4'd0; octave = 2'd1;
        @(negedge clk);
        run_len(1'b1, n);
        vectors++;
        if (n != 25) begin errors++; $display("FAIL oct1_high got %0d exp 25", n); end
        run_len(1'b0, n);
        vectors++;
        if (n != 25) begin errors++; $display("FAIL oct1_low got %0d exp 25", n); end
        do_reset();
        rst = 1'b0; octave = 2'd3; note_on = 1'b1;
        @(negedge clk);
        run_len(1'b1, n);
        vectors++;
        if (n != 6) begin errors++; $display("FAIL oct3_high got %0d exp 6", n); end
        run_len(1'b0, n);
        vectors++;
        if (n != 6) begin errors++; $display("FAIL oct3_low got %0d exp 6", n); end
    endtask

    task automatic test_note_change();
        int n;
        do_reset();
        rst = 1'b0; note_on = 1'b1; note_idx = 4'd0; octave = 2'd0;
        @(negedge clk);
        repeat (10) @(negedge clk);
        note_idx = 4'd5;
        run_len(1'b1, n);
        vectors++;
        if (10 + n != 50) begin errors++; $display("FAIL chg_old_high got %0d exp 50", 10 + n); end
        vectors++;
        if (note_cur !== 4'd0) begin errors++; $display("FAIL chg_note_low got %0d exp 0", note_cur); end
        run_len(1'b0, n);
        vectors++;
        if (n != 50) begin errors++; $display("FAIL chg_old_low got %0d exp 50", n); end
        vectors++;
        if (note_cur !== 4'd5) begin errors++; $display("FAIL chg_note_new got %0d exp 5", note_cur); end
        run_len(1'b1, n);
        vectors++;
        if (n != 29) begin errors++; $display("FAIL chg_new_high got %0d exp 29", n); end
        run_len(1'b0, n);
        vectors++;
        if (n != 29) begin errors++; $display("FAIL chg_new_low got %0d exp 29", n); end
    endtask

    task automatic test_note_off();
        int n;
        do_reset();
        rst = 1'b0; note_on = 1'b1; note_idx = 4'd0; octave = 2'd0;
        @(negedge clk);
        repeat (10) @(negedge clk);
        note_on = 1'b0;
        run_len(1'b1, n);
        vectors++;
        if (10 + n != 50) begin errors++; $display("FAIL off_high got %0d exp 50", 10 + n); end
        n = 0;
        while (busy === 1'b1 && wave === 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 50) begin errors++; $display("FAIL off_low got %0d exp 50", n); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (busy !== 1'b0 || wave !== 1'b0) begin
                errors++; $display("FAIL off_idle cyc%0d got busy=%b wave=%b exp busy=0 wave=0", i, busy, wave);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_glitch();
        int n;
        do_reset();
        rst = 1'b0; note_on = 1'b1; note_idx = 4'd0; octave = 2'd0;
        @(negedge clk);
        repeat (10) @(negedge clk);
        note_on = 1'b0;
        repeat (3) @(negedge clk);
        note_on = 1'b1;
        run_len(1'b1, n);
        vectors++;
        if (13 + n != 50) begin errors++; $display("FAIL glitch_high got %0d exp 50", 13 + n); end
        run_len(1'b0, n);
        vectors++;
        if (n != 50) begin errors++; $display("FAIL glitch_low got %0d exp 50", n); end
        vectors++;
        if (wave !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL glitch_resume got wave=%b busy=%b exp wave=1 busy=1", wave, busy);
        end
    endtask

    task automatic test_invalid_and_rst();
        int n;
        do_reset();
        rst = 1'b0; note_on = 1'b1; note_idx = 4'd14; octave = 2'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (wave !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL invalid_idx cyc%0d got wave=%b busy=%b exp 0 0", i, wave, busy);
            end
        end
        note_idx = 4'd13;
        @(negedge clk);
        run_len(1'b1, n);
        vectors++;
        if (n != 13) begin errors++; $display("FAIL idx13_high got %0d exp 13", n); end
        run_len(1'b0, n);
        vectors++;
        if (n != 13) begin errors++; $display("FAIL idx13_low got %0d exp 13", n); end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (wave !== 1'b0 || busy !== 1'b0 || note_cur !== 4'd0) begin
            errors++; $display("FAIL rst_play got wave=%b busy=%b note=%0d exp 0 0 0", wave, busy, note_cur);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (wave !== 1'b1 || busy !== 1'b1 || note_cur !== 4'd13) begin
            errors++; $display("FAIL rst_restart got wave=%b busy=%b note=%0d exp 1 1 13", wave, busy, note_cur);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_octave();
        test_note_change();
        test_note_off();
        test_glitch();
        test_invalid_and_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
